image_mem_streamer: RTL and testbench
=====================================

# image_mem_streamer

Reads a rectangular pixel window out of the processor-local on-chip image memory (32-bit words, 17-bit word address, single-port, 1-cycle read latency, no waitrequest) and emits it as an Avalon-ST stream of 32-bit pixels with frame/line markers. It sits directly downstream of the image memory, drives that memory's read-side signals, and feeds the per-processor filter pipeline. An internal credit-checked FIFO absorbs downstream backpressure, so no read is ever lost.

## Interface
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `ADDR_W`, 17: memory word-address width.
- `clk` in 1: sole clock.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request, sampled only in IDLE.
- `base_addr` in ADDR_W: word address of pixel (0,0); sampled with `start`.
- `win_width` in 10: pixels per row; sampled with `start`.
- `win_height` in 10: rows; sampled with `start`.
- `stride` in ADDR_W: words between row starts; sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at end of frame or on rejected start.
- `err` out 1: valid with `done`; 1 = rejected (zero width/height).
- `mem_address` out ADDR_W: read address to memory.
- `mem_chipselect` out 1: high on read-issue cycles.
- `mem_write` out 1: constant 0.
- `mem_clken` out 1: constant 1 out of reset.
- `mem_readdata` in 32: memory data, valid one cycle after issue.
- `src_data` out 32, `src_valid` out 1, `src_ready` in 1: Avalon-ST source.
- `src_sop` out 1: first pixel of frame. `src_eol` out 1: last pixel of row. `src_eop` out 1: last pixel of frame.
- `perf_stall_cycles` out 32: see Configuration.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `start`=1 with width≠0 and height≠0 → latch config, row=col=0, row_base=base_addr, → RUN. With width=0 or height=0 → stay IDLE, `done`=1 and `err`=1 next cycle.
- RUN: issue read when `count + inflight + push_pending < FIFO_DEPTH` (`push_pending` = read issued last cycle; pops same cycle not credited). Issue: `mem_chipselect`=1, `mem_address`=row_base+col (mod 2^ADDR_W). Advance col; at col=width-1 → col=0, row+1, row_base+=stride (mod 2^ADDR_W). After issuing (width-1,height-1) → DRAIN.
- Tag per issued read (sop/eol/eop) travels with the pipeline register into the FIFO alongside `mem_readdata`.
- DRAIN: no issues; when FIFO empty, no read in flight and no pop pending → IDLE, `done`=1 (`err`=0) for one cycle.
- `start` while busy: ignored, no effect on `done`/`err`.
- Address wrap past 2^ADDR_W−1 wraps to 0; range against the memory depth is the software's responsibility.
- Reset (any state): to IDLE, FIFO and in-flight tag flushed, all outputs 0 except `mem_clken`=0 during reset, 1 after.

## Timing
- Cycle 0 `start` sampled; cycle 1 first `mem_chipselect`; cycle 2 `mem_readdata` captured into FIFO; cycle 3 first `src_valid`.
- Without backpressure: one pixel per cycle sustained; last beat at cycle W·H+2; `done` at cycle W·H+3; `busy` low same cycle as `done`.
- Beat transfers when `src_valid & src_ready`; `src_data`/flags stable while `src_valid & ~src_ready`.
- FIFO simultaneous push and pop: count unchanged; never overflows given credit rule.
- Rejected start: `done`/`err` at cycle 1, `busy` never asserted.

## Configuration
- `IMG_STREAM_PERF_EN` defined: `perf_stall_cycles` counts cycles with `src_valid & ~src_ready` while busy; cleared on accepted `start` and reset; saturates at 2^32−1.
- Undefined: counter not built, `perf_stall_cycles` tied to 0.

## Test plan
- base=0x100, W=4, H=2, stride=4, `src_ready`=1 → addresses 0x100..0x107, 8 beats, sop on beat 0, eol on beats 3 and 7, eop on beat 7, `done` at cycle 11, err=0.
- W=3, H=2, stride=8, base=0x10 → reads 0x10,0x11,0x12,0x18,0x19,0x1A only.
- Same 4×2 frame, `src_ready` toggling 1010… → data order intact, no beat lost/duplicated, FIFO count ≤ FIFO_DEPTH, with PERF_EN stall count equals ready-low cycles with valid high.
- `start` with W=0, H=5 → no `mem_chipselect`, `done`=1 and `err`=1 at cycle 1, `busy` stays 0.
- base=0x1FFFE, W=4, H=1 → addresses 0x1FFFE,0x1FFFF,0x00000,0x00001.
- `reset_n`=0 for one cycle mid-frame (beat 3 of 8), then new `start` → no stale beats; new frame starts with sop, `busy`/`src_valid`/`done` 0 during reset.

Source files
------------

// File: rtl/image_mem_streamer.sv
// Streams a rectangular window of the on-chip image memory out as an Avalon-ST pixel stream.
// Optional stall counter enabled by defining IMG_STREAM_PERF_EN.
module image_mem_streamer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [9:0]        win_width,
    input  logic [9:0]        win_height,
    input  logic [ADDR_W-1:0] stride,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eol,
    output logic              src_eop,
    output logic [31:0]       perf_stall_cycles
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [9:0]        width_q, width_d;
    logic [9:0]        height_q, height_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [9:0]        row_q, row_d;
    logic [9:0]        col_q, col_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              push_q, push_d;
    logic [2:0]        tag_q, tag_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [31:0]       fifo_data_q [FIFO_DEPTH];
    logic [2:0]        fifo_tag_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic issue;
    logic pop;
    logic credit_ok;
    logic start_accept;
    logic last_col;
    logic last_row;

    // Credit excludes same-cycle pops so the FIFO can never overflow.
    assign credit_ok = (32'(count_q) + 32'(push_q)) < FIFO_DEPTH;
    assign last_col  = (col_q == width_q - 10'd1);
    assign last_row  = (row_q == height_q - 10'd1);
    assign pop       = src_valid & src_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_q) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_q && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_q && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        stride_d     = stride_q;
        row_d        = row_q;
        col_d        = col_q;
        row_base_d   = row_base_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        issue        = 1'b0;
        start_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (win_width == 10'd0 || win_height == 10'd0) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        start_accept = 1'b1;
                        width_d      = win_width;
                        height_d     = win_height;
                        stride_d     = stride;
                        row_d        = 10'd0;
                        col_d        = 10'd0;
                        row_base_d   = base_addr;
                        state_d      = RUN;
                    end
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (last_col) begin
                        col_d      = 10'd0;
                        row_d      = row_q + 10'd1;
                        row_base_d = row_base_q + stride_q;
                        if (last_row) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                end
            end
            DRAIN: begin
                if (count_d == CNT_W'(0) && !push_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag order is {sop, eol, eop}; it rides with the read into the FIFO.
    always_comb begin
        push_d = issue;
        tag_d  = {(row_q == 10'd0) && (col_q == 10'd0), last_col, last_col && last_row};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            width_q    <= '0;
            height_q   <= '0;
            stride_q   <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            push_q     <= 1'b0;
            tag_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_tag_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            stride_q   <= stride_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            push_q     <= push_d;
            tag_q      <= tag_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (push_q) begin
                fifo_data_q[wr_ptr_q] <= mem_readdata;
                fifo_tag_q[wr_ptr_q]  <= tag_q;
            end
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign err            = err_q;
    assign mem_chipselect = issue;
    assign mem_address    = row_base_q + ADDR_W'(col_q);
    assign mem_write      = 1'b0;
    assign mem_clken      = reset_n;
    assign src_valid      = (count_q != CNT_W'(0));
    assign src_data       = fifo_data_q[rd_ptr_q];
    assign {src_sop, src_eol, src_eop} = fifo_tag_q[rd_ptr_q];

`ifdef IMG_STREAM_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_accept) begin
            stall_d = '0;
        end else if (busy && src_valid && !src_ready && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign perf_stall_cycles = stall_q;
`else
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_image_mem_streamer.sv
// Randomized self-checking bench for image_mem_streamer against an address/beat reference model.
module tb_image_mem_streamer;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned ADDR_W     = 17;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [9:0]        win_width;
    logic [9:0]        win_height;
    logic [ADDR_W-1:0] stride;
    logic              busy, done, err;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [31:0]       mem_readdata;
    logic [31:0]       src_data;
    logic              src_valid, src_ready;
    logic              src_sop, src_eol, src_eop;
    logic [31:0]       perf_stall_cycles;

    always #5 clk = ~clk;

    image_mem_streamer #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .win_width(win_width), .win_height(win_height), .stride(stride),
        .busy(busy), .done(done), .err(err), .mem_address(mem_address),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .src_sop(src_sop), .src_eol(src_eol), .src_eop(src_eop),
        .perf_stall_cycles(perf_stall_cycles)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] salt = 32'h0;

    function automatic logic [31:0] mem_word(input logic [16:0] a);
        return ({15'd0, a} * 32'h9E37_79B1) ^ salt;
    endfunction

    // 1-cycle-latency memory; junk on idle cycles exposes timing slips.
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem_word(mem_address);
        else mem_readdata <= $urandom;
    end

    // Reference model: expected read addresses and beats ({sop,eol,eop}).
    logic [16:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [2:0]  exp_flags[$];

    task automatic build_model(input logic [16:0] b, input int w, input int h,
                               input logic [16:0] s);
        int unsigned a;
        exp_addr.delete(); exp_data.delete(); exp_flags.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                a = (32'(b) + r * 32'(s) + c) & 32'h1FFFF;
                exp_addr.push_back(a[16:0]);
                exp_data.push_back(mem_word(a[16:0]));
                exp_flags.push_back({(r == 0 && c == 0), (c == w - 1),
                                     (c == w - 1 && r == h - 1)});
            end
        end
    endtask

    // Observations of one frame.
    logic [16:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [2:0]  obs_flags[$];
    int done_cyc, first_valid_cyc, max_out, stall_exp, hold_viol;
    logic done_err, busy_seen, busy_c1, busy_at_done;
    logic [31:0] perf_at_done;

    function automatic int pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1;
        if (mode == 1) return (cyc % 2 == 0) ? 1 : 0;
        return ($urandom_range(0, 9) < 6) ? 1 : 0;
    endfunction

    function automatic int addr_diff();
        if (obs_addr.size() != exp_addr.size()) return obs_addr.size();
        foreach (exp_addr[i]) if (obs_addr[i] !== exp_addr[i]) return i;
        return -1;
    endfunction

    function automatic int beat_diff();
        if (obs_data.size() != exp_data.size()) return obs_data.size();
        foreach (exp_data[i])
            if (obs_data[i] !== exp_data[i] || obs_flags[i] !== exp_flags[i]) return i;
        return -1;
    endfunction

    task automatic run_frame(input logic [16:0] b, input int w, input int h,
                             input logic [16:0] s, input int mode, input int abort_beats);
        int issued, popped;
        logic hold_pending;
        logic [31:0] hold_data;
        logic [2:0]  hold_flags;
        obs_addr.delete(); obs_data.delete(); obs_flags.delete();
        done_cyc = -1; first_valid_cyc = -1; max_out = 0; stall_exp = 0; hold_viol = 0;
        done_err = 1'b0; busy_seen = 1'b0; busy_c1 = 1'b0; busy_at_done = 1'b1;
        perf_at_done = 32'hDEAD_BEEF;
        issued = 0; popped = 0; hold_pending = 1'b0; hold_data = '0; hold_flags = '0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; win_width = w[9:0]; win_height = h[9:0]; stride = s;
        src_ready = pick_ready(mode, 0) != 0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            src_ready = pick_ready(mode, cyc) != 0;
            if (busy) busy_seen = 1'b1;
            if (cyc == 1) busy_c1 = busy;
            if (hold_pending && (!src_valid || src_data !== hold_data ||
                                 {src_sop, src_eol, src_eop} !== hold_flags))
                hold_viol++;
            if (mem_chipselect) begin
                obs_addr.push_back(mem_address);
                issued++;
            end
            if (busy && src_valid && !src_ready) stall_exp++;
            if (src_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (src_valid && src_ready) begin
                obs_data.push_back(src_data);
                obs_flags.push_back({src_sop, src_eol, src_eop});
                popped++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            hold_pending = src_valid && !src_ready;
            hold_data = src_data;
            hold_flags = {src_sop, src_eol, src_eop};
            if (done) begin
                done_cyc = cyc; done_err = err; busy_at_done = busy;
                perf_at_done = perf_stall_cycles;
                start = 1'b0;
                break;
            end
            if (abort_beats >= 0 && popped >= abort_beats) begin
                start = 1'b0;
                break;
            end
            // Junk config with start pulses while busy must be ignored.
            start = (mode == 2) ? ($urandom_range(0, 1) != 0) : 1'b0;
            base_addr = 17'($urandom); win_width = 10'($urandom_range(0, 3));
            win_height = 10'($urandom_range(0, 3)); stride = 17'($urandom);
        end
        src_ready = 1'b1;
    endtask

    function automatic logic [31:0] perf_expect(input int stalls);
`ifdef IMG_STREAM_PERF_EN
        return 32'(stalls);
`else
        return 32'(stalls) & 32'h0;
`endif
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; src_ready = 1'b1;
        base_addr = '0; win_width = '0; win_height = '0; stride = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, err, src_valid, mem_chipselect, mem_write, mem_clken} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {busy, done, err, src_valid, mem_chipselect, mem_write, mem_clken});
        end
        vectors++;
        if (perf_stall_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_perf: got %0d want 0", perf_stall_cycles);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({mem_clken, mem_write, busy, src_valid} !== 4'b1000) begin
            miscompares++;
            $display("FAIL post_reset: got %b want 1000", {mem_clken, mem_write, busy, src_valid});
        end
    endtask

    task automatic test_basic_frame();
        int d;
        salt = $urandom;
        build_model(17'h100, 4, 2, 17'd4);
        run_frame(17'h100, 4, 2, 17'd4, 0, -1);
        d = addr_diff();
        vectors++;
        if (d !== -1) begin
            miscompares++;
            $display("FAIL basic_addr: first diff at %0d, got %0d reads want %0d", d,
                     obs_addr.size(), exp_addr.size());
        end
        d = beat_diff();
        vectors++;
        if (d !== -1) begin
            miscompares++;
            $display("FAIL basic_beats: first diff at beat %0d, got %0d beats want %0d", d,
                     obs_data.size(), exp_data.size());
        end
        vectors++;
        if (done_cyc !== 11 || done_err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: got cycle %0d err %b want cycle 11 err 0", done_cyc, done_err);
        end
        vectors++;
        if (first_valid_cyc !== 3 || busy_c1 !== 1'b1 || busy_at_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_timing: got valid@%0d busy1=%b busy_done=%b want 3 1 0",
                     first_valid_cyc, busy_c1, busy_at_done);
        end
        @(posedge clk); #1;
        vectors++;
        if ({src_valid, done, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL basic_after: got %b want 000", {src_valid, done, busy});
        end
    endtask

    task automatic test_stride();
        int d;
        salt = $urandom;
        build_model(17'h10, 3, 2, 17'd8);
        run_frame(17'h10, 3, 2, 17'd8, 0, -1);
        d = addr_diff();
        vectors++;
        if (d !== -1) begin
            miscompares++;
            $display("FAIL stride_addr: first diff at %0d, got %0d reads want %0d", d,
                     obs_addr.size(), exp_addr.size());
        end
        d = beat_diff();
        vectors++;
        if (d !== -1 || done_cyc !== 9) begin
            miscompares++;
            $display("FAIL stride_beats: diff at %0d done at %0d want -1 and 9", d, done_cyc);
        end
    endtask

    task automatic test_backpressure();
        int d;
        salt = $urandom;
        build_model(17'h100, 4, 2, 17'd4);
        run_frame(17'h100, 4, 2, 17'd4, 1, -1);
        d = beat_diff();
        vectors++;
        if (d !== -1 || done_cyc < 0 || done_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_beats: diff at %0d done at %0d err %b want -1, done, 0",
                     d, done_cyc, done_err);
        end
        vectors++;
        if (max_out > FIFO_DEPTH || hold_viol !== 0) begin
            miscompares++;
            $display("FAIL bp_fifo: got occupancy %0d hold_viol %0d want <=%0d and 0",
                     max_out, hold_viol, FIFO_DEPTH);
        end
        vectors++;
        if (perf_at_done !== perf_expect(stall_exp)) begin
            miscompares++;
            $display("FAIL bp_perf: got %0d want %0d", perf_at_done, perf_expect(stall_exp));
        end
    endtask

    task automatic test_reject();
        run_frame(17'h40, 0, 5, 17'd4, 0, -1);
        vectors++;
        if (done_cyc !== 1 || done_err !== 1'b1) begin
            miscompares++;
            $display("FAIL reject_done: got cycle %0d err %b want 1 1", done_cyc, done_err);
        end
        vectors++;
        if (obs_addr.size() !== 0 || busy_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL reject_quiet: got %0d reads busy_seen %b want 0 0",
                     obs_addr.size(), busy_seen);
        end
    endtask

    task automatic test_wrap();
        int d;
        salt = $urandom;
        build_model(17'h1FFFE, 4, 1, 17'd0);
        run_frame(17'h1FFFE, 4, 1, 17'd0, 0, -1);
        d = addr_diff();
        vectors++;
        if (d !== -1) begin
            miscompares++;
            $display("FAIL wrap_addr: first diff at %0d, got %0d reads want %0d", d,
                     obs_addr.size(), exp_addr.size());
        end
        d = beat_diff();
        vectors++;
        if (d !== -1) begin
            miscompares++;
            $display("FAIL wrap_beats: first diff at beat %0d", d);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d;
        salt = $urandom;
        run_frame(17'h200, 4, 2, 17'd4, 0, 3);
        reset_n = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({busy, src_valid, done, mem_chipselect, mem_clken} !== 5'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %b want 00000",
                     {busy, src_valid, done, mem_chipselect, mem_clken});
        end
        reset_n = 1'b1;
        salt = $urandom;
        build_model(17'h300, 4, 2, 17'd5);
        run_frame(17'h300, 4, 2, 17'd5, 0, -1);
        d = beat_diff();
        vectors++;
        if (d !== -1 || done_cyc !== 11) begin
            miscompares++;
            $display("FAIL midreset_frame: diff at %0d done at %0d want -1 and 11", d, done_cyc);
        end
    endtask

    task automatic test_random();
        int d, w, h;
        logic [16:0] b, s;
        for (int n = 0; n < 4; n++) begin
            salt = $urandom;
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            b = 17'($urandom);
            s = 17'($urandom);
            build_model(b, w, h, s);
            run_frame(b, w, h, s, 2, -1);
            d = addr_diff();
            vectors++;
            if (d !== -1) begin
                miscompares++;
                $display("FAIL rand%0d_addr: first diff at %0d (w=%0d h=%0d)", n, d, w, h);
            end
            d = beat_diff();
            vectors++;
            if (d !== -1 || done_cyc < 0 || done_err !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d_beats: diff at %0d done at %0d err %b", n, d, done_cyc,
                         done_err);
            end
            vectors++;
            if (max_out > FIFO_DEPTH || hold_viol !== 0 ||
                perf_at_done !== perf_expect(stall_exp)) begin
                miscompares++;
                $display("FAIL rand%0d_flow: got occ %0d hold %0d perf %0d want <=%0d 0 %0d", n,
                         max_out, hold_viol, perf_at_done, FIFO_DEPTH, perf_expect(stall_exp));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stride();
        test_backpressure();
        test_reject();
        test_wrap();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
